// File: rtl/ase_pkg.sv
// ase_pkg: shared ASE types used by the UMsg engine and its slots.
//   NUM_UMSG_PER_AFU    - number of UMsg slots exposed to one AFU
//   UMsg_StateEnum      - per-slot UMsg lifecycle state
//   ccip_resptype_t     - C0 Rx response type encoding (ASE_UMSG = 4'h6)
//   umsg_t              - one 512-bit UMsg cache line
//   UMsgHdr_t           - C0 Rx UMsg header; ASE_UMSG_HDR_WIDTH is its width
package ase_pkg;

  localparam int NUM_UMSG_PER_AFU    = 8;
  localparam int ASE_UMSG_DATA_WIDTH = 512;

  typedef enum logic [2:0] {
    UMsgIdle     = 3'd0,
    UMsgHintWait = 3'd1,
    UMsgSendHint = 3'd2,
    UMsgDataWait = 3'd3,
    UMsgSendData = 3'd4
  } UMsg_StateEnum;

  typedef enum logic [3:0] {
    ASE_RDLINE_RSP  = 4'h0,
    ASE_WRLINE_RSP  = 4'h1,
    ASE_WRFENCE_RSP = 4'h4,
    ASE_UMSG        = 4'h6,
    ASE_INTR_RSP    = 4'h8
  } ccip_resptype_t;

  typedef logic [ASE_UMSG_DATA_WIDTH-1:0] umsg_t;

  typedef struct packed {
    logic [1:0]     vc_used;
    logic           rsvd_a;
    logic           hit_miss;
    logic [1:0]     rsvd_b;
    ccip_resptype_t resp_type;
    logic           umsg_type;
    logic [11:0]    rsvd_c;
    logic [5:0]     umsg_id;
  } UMsgHdr_t;

  localparam int ASE_UMSG_HDR_WIDTH = $bits(UMsgHdr_t);

endpackage

// File: rtl/ase_umsg_slot.sv
// ase_umsg_slot: one UMsg slot -- lifecycle FSM, delay timer and line buffer.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   accept    - a command for this slot was accepted this cycle (UMsg enabled)
//   hint      - this slot sends a hint before its data
//   grant     - the output register is taking this slot's pending message
//   cmd_data  - line data of the accepted command
//   state     - current slot state
//   data      - stored (latest, coalesced) line data
module ase_umsg_slot
  import ase_pkg::*;
#(
  parameter int DELAY_LOG2 = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          accept,
  input  logic          hint,
  input  logic          grant,
  input  logic [511:0]  cmd_data,
  output UMsg_StateEnum state,
  output logic [511:0]  data
);

  // Delay D = 2^DELAY_LOG2 - 1, i.e. the timer loaded with all ones.
  localparam logic [DELAY_LOG2-1:0] DELAY = '1;

  UMsg_StateEnum          state_q, state_d;
  logic [DELAY_LOG2-1:0]  timer_q, timer_d;
  umsg_t                  data_q, data_d;
  logic                   hold_q, hold_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UMsgIdle;
      timer_q <= '0;
      data_q  <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
    end
  end

  // A later write while the message is still pending simply replaces the
  // line (coalescing); accept never arrives in SendData because cmd_ready
  // is low there. After a hint leaves, the data wait is held one extra
  // cycle (hold_q) so the data follows the hint by D+3 cycles.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    data_d  = data_q;
    hold_d  = hold_q;
    if (accept) begin
      data_d = cmd_data;
    end
    case (state_q)
      UMsgIdle: begin
        if (accept) begin
          timer_d = DELAY;
          hold_d  = 1'b0;
          state_d = hint ? UMsgHintWait : UMsgDataWait;
        end
      end
      UMsgHintWait: begin
        if (timer_q == '0) begin
          state_d = UMsgSendHint;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      UMsgSendHint: begin
        if (grant) begin
          state_d = UMsgDataWait;
          timer_d = DELAY;
          hold_d  = 1'b1;
        end
      end
      UMsgDataWait: begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else if (timer_q == '0) begin
          state_d = UMsgSendData;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      UMsgSendData: begin
        if (grant) begin
          state_d = UMsgIdle;
        end
      end
      default: state_d = UMsgIdle;
    endcase
  end

  assign state = state_q;
  assign data  = data_q;

endmodule

// File: rtl/ase_umsg_engine.sv
// ase_umsg_engine: UMsg engine -- NUM_UMSG slots, round-robin arbiter and a
// one-entry C0 Rx output register.
// Configuration macro: ASE_UMSG_HINT_EN enables the per-ID hint path; when
// undefined, hint_en is ignored and every message is a data UMsg.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   umsg_en               - global UMsg enable (accepted commands dropped if 0)
//   hint_en               - per-ID hint enable
//   cmd_valid/cmd_ready   - software UMsg write handshake
//   cmd_id, cmd_data      - target slot and line data
//   rx_valid/rx_ready     - C0 Rx insertion handshake
//   rx_hdr, rx_data       - UMsg header and data
//   busy                  - per-slot "not idle"
module ase_umsg_engine
  import ase_pkg::*;
#(
  parameter int NUM_UMSG   = NUM_UMSG_PER_AFU,
  parameter int DELAY_LOG2 = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          umsg_en,
  input  logic [NUM_UMSG-1:0]           hint_en,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [$clog2(NUM_UMSG)-1:0]   cmd_id,
  input  logic [511:0]                  cmd_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [ASE_UMSG_HDR_WIDTH-1:0] rx_hdr,
  output logic [511:0]                  rx_data,
  output logic [NUM_UMSG-1:0]           busy
);

  localparam int ID_W = $clog2(NUM_UMSG);

  UMsg_StateEnum       slot_state [NUM_UMSG];
  umsg_t               slot_data  [NUM_UMSG];
  logic [NUM_UMSG-1:0] slot_hint;
  logic [NUM_UMSG-1:0] slot_accept;
  logic [NUM_UMSG-1:0] slot_grant;
  logic [NUM_UMSG-1:0] slot_req;

  logic                cmd_accept;
  logic                load_out;
  logic                found;
  logic [ID_W-1:0]     win;
  logic [ID_W-1:0]     cand;
  logic [ID_W-1:0]     rr_ptr;
  logic                win_is_hint;
  UMsgHdr_t            hdr_next;

`ifdef ASE_UMSG_HINT_EN
  assign slot_hint = hint_en;
`else
  logic unused_hint_en;
  assign unused_hint_en = ^hint_en;
  assign slot_hint      = '0;
`endif

  // A slot waiting in SendData must not be rewritten: its line is about to
  // be sent, so the writer is back-pressured instead.
  assign cmd_ready  = (slot_state[cmd_id] != UMsgSendData);
  assign cmd_accept = cmd_valid & cmd_ready & umsg_en;
  assign load_out   = ~rx_valid | rx_ready;

  for (genvar i = 0; i < NUM_UMSG; i++) begin : g_slot
    assign slot_accept[i] = cmd_accept & (cmd_id == ID_W'(i));
    assign slot_grant[i]  = load_out & found & (win == ID_W'(i));
    assign slot_req[i]    = (slot_state[i] == UMsgSendHint) |
                            (slot_state[i] == UMsgSendData);
    assign busy[i]        = (slot_state[i] != UMsgIdle);

    ase_umsg_slot #(
      .DELAY_LOG2(DELAY_LOG2)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .accept  (slot_accept[i]),
      .hint    (slot_hint[i]),
      .grant   (slot_grant[i]),
      .cmd_data(cmd_data),
      .state   (slot_state[i]),
      .data    (slot_data[i])
    );
  end

  // Round-robin search starting just after the last winner, wrapping so the
  // last winner itself is considered last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int off = 1; off <= NUM_UMSG; off++) begin
      cand = ID_W'((int'(rr_ptr) + off) % NUM_UMSG);
      if (!found && slot_req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    win_is_hint        = (slot_state[win] == UMsgSendHint);
    hdr_next           = '0;
    hdr_next.resp_type = ASE_UMSG;
    hdr_next.umsg_type = win_is_hint;
    hdr_next.umsg_id   = 6'(win);
  end

  // One-entry output register: refills whenever it is empty or being drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid <= 1'b0;
      rx_hdr   <= '0;
      rx_data  <= '0;
      rr_ptr   <= ID_W'(NUM_UMSG - 1);
    end else if (load_out) begin
      rx_valid <= found;
      if (found) begin
        rx_hdr  <= hdr_next;
        rx_data <= win_is_hint ? '0 : slot_data[win];
        rr_ptr  <= win;
      end
    end
  end

endmodule

// File: tb/tb_ase_umsg_engine.sv
// tb_ase_umsg_engine: directed, table-driven bench for ase_umsg_engine
// (NUM_UMSG=8, D=15), plus hand-written multi-cycle sequences for
// coalescing, arbitration under back-pressure, hints, reset and disable.
module tb_ase_umsg_engine;
  import ase_pkg::*;

  localparam int NUM_UMSG = 8;
  localparam int D        = 15;

  logic                          clk;
  logic                          rst;
  logic                          umsg_en;
  logic [NUM_UMSG-1:0]           hint_en;
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [2:0]                    cmd_id;
  logic [511:0]                  cmd_data;
  logic                          rx_valid;
  logic                          rx_ready;
  logic [ASE_UMSG_HDR_WIDTH-1:0] rx_hdr;
  logic [511:0]                  rx_data;
  logic [NUM_UMSG-1:0]           busy;

  ase_umsg_engine #(
    .NUM_UMSG  (NUM_UMSG),
    .DELAY_LOG2(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .umsg_en  (umsg_en),
    .hint_en  (hint_en),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_id   (cmd_id),
    .cmd_data (cmd_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_hdr   (rx_hdr),
    .rx_data  (rx_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] id;
    logic [7:0] pat;
    int         exp_lat;
  } vec_t;

  vec_t         vecs [4];
  int           checks = 0;
  int           errors = 0;
  int           n;
  int           cnt;
  int           bad;
  logic [511:0] snap_data;
  logic [ASE_UMSG_HDR_WIDTH-1:0] snap_hdr;
  logic [7:0]   exp_busy;

  function automatic logic [511:0] fill(input logic [7:0] b);
    return {64{b}};
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] id, input logic [511:0] d);
    cmd_valid = 1'b1;
    cmd_id    = id;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic waitRx(input int max_ticks, output int ticks);
    ticks = 0;
    do begin
      tick();
      ticks++;
    end while (!rx_valid && ticks < max_ticks);
  endtask

  task automatic checkRx(input string name, input logic [2:0] id, input logic typ, input logic [511:0] d);
    UMsgHdr_t h;
    h           = '0;
    h.resp_type = ASE_UMSG;
    h.umsg_type = typ;
    h.umsg_id   = 6'(id);
    checkOutput({name, "_valid"}, rx_valid, 1'b1);
    checkOutput({name, "_hdr"}, rx_hdr, h);
    checkOutput({name, "_data"}, rx_data, d);
  endtask

  task automatic countRx(input int ticks, output int seen);
    seen = 0;
    for (int i = 0; i < ticks; i++) begin
      tick();
      if (rx_valid) seen++;
    end
  endtask

  initial begin
    vecs[0] = '{3'd3, 8'hA5, D + 2};
    vecs[1] = '{3'd0, 8'h3C, D + 2};
    vecs[2] = '{3'd7, 8'hFF, D + 2};
    vecs[3] = '{3'd5, 8'h01, D + 2};

    rst       = 1'b1;
    umsg_en   = 1'b1;
    hint_en   = '0;
    cmd_valid = 1'b0;
    cmd_id    = '0;
    cmd_data  = '0;
    rx_ready  = 1'b1;
    tick();
    tick();
    checkOutput("rst_rx_valid", rx_valid, 1'b0);
    checkOutput("rst_busy", busy, 8'h00);
    checkOutput("rst_rx_hdr", rx_hdr, '0);
    checkOutput("rst_rx_data", rx_data, '0);
    checkOutput("rst_cmd_ready", cmd_ready, 1'b1);
    rst = 1'b0;
    tick();

    // Basic data UMsgs, hint off: rx_valid D+2 ticks after the accept edge.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].id, fill(vecs[i].pat));
      exp_busy = '0;
      exp_busy[vecs[i].id] = 1'b1;
      checkOutput("tbl_busy_set", busy, exp_busy);
      waitRx(40, n);
      checkOutput("tbl_latency", n, vecs[i].exp_lat);
      checkRx("tbl_rx", vecs[i].id, 1'b0, fill(vecs[i].pat));
      checkOutput("tbl_busy_clear", busy, 8'h00);
      tick();
      checkOutput("tbl_drain", rx_valid, 1'b0);
    end

    // Hint path on ID 2.
    hint_en = 8'b0000_0100;
    applyStimulus(3'd2, fill(8'h5A));
    waitRx(40, n);
    checkOutput("hint_latency", n, D + 2);
`ifdef ASE_UMSG_HINT_EN
    checkRx("hint_rx", 3'd2, 1'b1, '0);
    waitRx(40, n);
    checkOutput("hint_data_latency", n, D + 3);
    checkRx("hint_data_rx", 3'd2, 1'b0, fill(8'h5A));
    countRx(40, cnt);
    checkOutput("hint_no_extra", cnt, 0);
`else
    checkRx("nohint_rx", 3'd2, 1'b0, fill(8'h5A));
    countRx(40, cnt);
    checkOutput("nohint_no_extra", cnt, 0);
`endif
    hint_en = '0;

    // Coalescing: second write 5 cycles later, one UMsg at original timing.
    applyStimulus(3'd5, fill(8'h11));
    repeat (4) tick();
    applyStimulus(3'd5, fill(8'h22));
    waitRx(40, n);
    checkOutput("coal_latency", n, D + 2 - 5);
    checkRx("coal_rx", 3'd5, 1'b0, fill(8'h22));
    countRx(40, cnt);
    checkOutput("coal_single", cnt, 0);

    // Back-pressure and round robin: ID 4 held in the output register sets
    // the pointer to 4; IDs 1, 4, 6 then pile up in SendData.
    rx_ready = 1'b0;
    applyStimulus(3'd4, fill(8'h44));
    waitRx(40, n);
    checkRx("bp_first", 3'd4, 1'b0, fill(8'h44));
    snap_hdr  = rx_hdr;
    snap_data = rx_data;
    applyStimulus(3'd1, fill(8'h01));
    applyStimulus(3'd4, fill(8'h4A));
    applyStimulus(3'd6, fill(8'h66));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rx_valid !== 1'b1 || rx_hdr !== snap_hdr || rx_data !== snap_data) bad++;
    end
    checkOutput("bp_hold", bad, 0);
    checkOutput("bp_busy", busy, 8'h52);
    cmd_valid = 1'b1;
    cmd_id    = 3'd6;
    cmd_data  = fill(8'hEE);
    #1;
    checkOutput("bp_cmd_ready_6", cmd_ready, 1'b0);
    tick();
    cmd_valid = 1'b0;
    cmd_id    = 3'd3;
    #1;
    checkOutput("bp_cmd_ready_3", cmd_ready, 1'b1);
    rx_ready = 1'b1;
    #1;
    checkRx("rr_0", 3'd4, 1'b0, fill(8'h44));
    tick();
    checkRx("rr_1", 3'd6, 1'b0, fill(8'h66));
    tick();
    checkRx("rr_2", 3'd1, 1'b0, fill(8'h01));
    tick();
    checkRx("rr_3", 3'd4, 1'b0, fill(8'h4A));
    tick();
    checkOutput("rr_done", rx_valid, 1'b0);

    // Mid-operation reset with a held output and a slot in DataWait.
    rx_ready = 1'b0;
    applyStimulus(3'd0, fill(8'h0F));
    waitRx(40, n);
    checkRx("mrst_held", 3'd0, 1'b0, fill(8'h0F));
    applyStimulus(3'd3, fill(8'h33));
    repeat (5) tick();
    checkOutput("mrst_busy_before", busy, 8'h08);
    #2 rst = 1'b1;
    #1;
    checkOutput("mrst_rx_valid", rx_valid, 1'b0);
    checkOutput("mrst_busy", busy, 8'h00);
    checkOutput("mrst_rx_data", rx_data, '0);
    #2 rst = 1'b0;
    rx_ready = 1'b1;
    countRx(40, cnt);
    checkOutput("mrst_no_output", cnt, 0);

    // Global disable: accepted commands vanish.
    umsg_en = 1'b0;
    applyStimulus(3'd2, fill(8'hEE));
    checkOutput("dis_busy", busy, 8'h00);
    countRx(30, cnt);
    checkOutput("dis_no_output", cnt, 0);
    umsg_en = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ase_umsg_engine.md
ASE_UMSG_ENGINE -- requirements
Module: ase_umsg_engine

Interface
REQ-001 SHALL have parameter NUM_UMSG, default 8 (NUM_UMSG_PER_AFU), giving the number of UMsg slots/IDs.
REQ-002 SHALL have parameter DELAY_LOG2, default 4, giving the hint/data delay timer width; the delay D is 2^DELAY_LOG2-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port umsg_en, input, 1 bit: global UMsg enable.
REQ-006 SHALL have port hint_en, input, NUM_UMSG bits: per-ID hint enable.
REQ-007 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1): the software UMsg-write handshake.
REQ-008 SHALL have port cmd_id, input, $clog2(NUM_UMSG) bits: the target slot.
REQ-009 SHALL have port cmd_data, input, 512 bits: the UMsg line data.
REQ-010 SHALL have ports rx_valid (output, 1) and rx_ready (input, 1): the C0 Rx insertion handshake.
REQ-011 SHALL have port rx_hdr, output, ASE_UMSG_HDR_WIDTH bits: the UMsgHdr_t header.
REQ-012 SHALL have port rx_data, output, 512 bits: the UMsg data.
REQ-013 SHALL have port busy, output, NUM_UMSG bits: slot state is not UMsgIdle.

Function
REQ-014 SHALL keep one state per slot in UMsg_StateEnum: UMsgIdle, UMsgHintWait, UMsgSendHint, UMsgDataWait, UMsgSendData.
REQ-015 SHALL drive cmd_ready=0 when slot[cmd_id] is UMsgSendData, and 1 otherwise.
REQ-016 SHALL, on accept (cmd_valid & cmd_ready) with umsg_en=0, discard the command with no state change.
REQ-017 SHALL, on accept to an Idle slot, store cmd_data, load timer=D, and go to HintWait if hint_en[id]=1, else to DataWait.
REQ-018 SHALL, on accept to a slot in HintWait, SendHint or DataWait, overwrite the stored data (coalesce) and leave state and timer unchanged.
REQ-019 SHALL decrement the timer by 1 per cycle in a wait state and leave the wait state in the cycle the timer equals 0: HintWait goes to SendHint, DataWait goes to SendData.
REQ-020 SHALL select among slots in SendHint/SendData with a round-robin arbiter, searching from pointer+1; the pointer takes the winner ID on load.
REQ-021 SHALL use a one-entry output register that loads the winner when empty or when rx_valid & rx_ready.
REQ-022 SHALL, on load, move the winning slot from SendHint to DataWait (timer=D), or from SendData to Idle.
REQ-023 SHALL hold rx_valid, rx_hdr and rx_data stable until rx_ready.
REQ-024 SHALL drive rx_hdr with resp_type=ASE_UMSG (4'h6), umsg_type=1 for a hint or 0 for data, umsg_id=slot ID, and all other fields 0.
REQ-025 SHALL drive rx_data with the stored data for a data UMsg, and with 0 for a hint.
REQ-026 SHALL meet this latency for an accept in cycle k with hint off: DataWait in cycles k+1..k+D+1, SendData in cycle k+D+2, rx_valid high in cycle k+D+3 if the output register is free.
REQ-027 SHALL, when hint is on, add D+3 cycles to the REQ-026 latency when uncontended.
REQ-028 SHALL, when a slot reaches SendData in the same cycle a new command targets it, deassert cmd_ready per REQ-015.

Reset
REQ-029 SHALL, on rst, asynchronously set all slots to UMsgIdle, timers to 0, stored data to 0, the RR pointer to NUM_UMSG-1, and rx_valid, rx_hdr, rx_data and busy to 0.
REQ-030 SHALL discard all pending UMsgs and any held output on a mid-operation reset, with no rx_valid in the cycle following deassertion.

Configuration
REQ-031 SHALL, when ASE_UMSG_HINT_EN is defined, implement the hint path per hint_en.
REQ-032 SHALL, when ASE_UMSG_HINT_EN is undefined, ignore hint_en, never enter HintWait/SendHint, never emit umsg_type=1, and send every accept to DataWait.

Structure
REQ-033 SHALL take UMsg_StateEnum, umsg_t, UMsgHdr_t, ccip_resptype_t (ASE_UMSG) and NUM_UMSG_PER_AFU from ase_pkg, with no local duplicates.
REQ-034 SHALL implement each slot's FSM, timer and data register in sub-module ase_umsg_slot, instantiated NUM_UMSG times.
REQ-035 SHALL keep the arbiter and output register in the top level.

Verification
REQ-036 SHALL cover: hint off, D=15, ID 3, data 0xA5..A5, rx_ready=1, accept in cycle 10 -> rx_valid in cycle 28, umsg_id=3, type 0, resp_type 6, data 0xA5..A5; busy[3] clears on load.
REQ-037 SHALL cover: hint_en[2]=1 with macro on, accept in cycle 0 -> hint (type 1, data 0) in cycle 18, data UMsg in cycle 36.
REQ-038 SHALL cover: IDs 1, 4 and 6 reaching SendData in the same cycle with the pointer at 4 -> output order 6, 1, 4 on consecutive cycles.
REQ-039 SHALL cover: rx_ready=0 for 20 cycles -> rx_valid, hdr and data held constant; a second pending slot stays in SendData; cmd to that ID sees cmd_ready=0.
REQ-040 SHALL cover: two writes to ID 5 (0x11.., then 0x22.. 5 cycles later) -> a single UMsg carrying 0x22.. at the original timing.
REQ-041 SHALL cover: rst asserted mid-DataWait and while rx_valid=1 -> rx_valid=0 immediately, all busy=0, no UMsg afterward; with umsg_en=0, accepted commands produce no output.
